joystick_mapper_multi: RTL and testbench
========================================

# joystick_mapper_multi

Parametrised N-port joystick interface for the ZX-Uno Spectrum core on MEGA65. Debounces each low-active DB9-style input, applies per-port autofire with programmable rate, and maps every port independently onto Kempston, Fuller, Sinclair 1/2 or Cursor protocols. Each port has its own ZX-Uno configuration register. It sits between the board joystick pins, the Z80 I/O read mux and the keyboard column path.

## Interface
- NUM_PORTS, 2, number of joystick ports (1..4)
- DEB_CYCLES, 140000, direction debounce length in clk cycles (5 ms at 28 MHz)
- FIRE_DEB_CYCLES, 28000, fire debounce length in clk cycles (1 ms)
- CONFBASE, 8'h06, ZX-Uno register address of port 0 config; port i at CONFBASE+i
- KEMPSTON_ADDR, 8'h1F, Kempston port low byte
- FULLER_ADDR, 8'h7F, Fuller port low byte

Ports:
- clk  in  1  system clock, 28 MHz
- reset_n  in  1  asynchronous, active-low reset
- a  in  16  Z80 address bus
- iorq_n  in  1  Z80 IORQ, active low
- rd_n  in  1  Z80 RD, active low
- din  in  8  CPU write data
- dout  out  8  read data
- oe  out  1  dout valid for the current read
- zxuno_addr  in  8  ZX-Uno register index
- zxuno_regrd  in  1  ZX-Uno register read strobe
- zxuno_regwr  in  1  ZX-Uno register write strobe
- joy_in  in  6*NUM_PORTS  per port {fire2,fire1,up,down,left,right}, low active, asynchronous
- kbdcol_in  in  5  keyboard columns from matrix
- kbdcol_out  out  5  keyboard columns with joystick presses merged, low active
- vertical_retrace_int_n  in  1  frame interrupt, autofire time base

## Operation
- Config register per port: [2:0] mode (0 disabled, 1 Kempston, 2 Sinclair P1, 3 Sinclair P2, 4 Cursor, 5 Fuller, 6/7 treated as disabled), [3] autofire enable, [5:4] rate R, [7:6] write-ignored, read 0.
- Reset config: port 0 = 8'h01, port 1 = 8'h02, ports 2..3 = 8'h00.
- Write: zxuno_regwr and zxuno_addr==CONFBASE+i loads din into port i on the next clk edge.
- Input path per bit: two-flop synchronizer, inverted to active-high, then debouncer. The debouncer holds state S and counter C. If sync==S, C clears. Otherwise C increments, and when C reaches limit-1, S takes sync and C clears. Fire bits use FIRE_DEB_CYCLES; direction bits use DEB_CYCLES.
- Autofire: the rising edge of vertical_retrace_int_n is detected with a registered previous value and shared by all ports. Each port has a 4-bit frame counter F. F increments on each edge while debounced fire1 is held and clears while it is released. Effective fire1 = fire1 & (~conf[3] | ~F[R]).
- ZX-Uno read (zxuno_regrd and zxuno_addr==CONFBASE+i): oe=1, dout=config i. This has priority over Z80 reads.
- Kempston read (iorq_n=0, rd_n=0, a[7:0]==KEMPSTON_ADDR): oe=1, dout = OR over Kempston-mode ports of {2'b00,fire2,fire1,up,down,left,right}. Result is 8'h00 if no port is in Kempston mode.
- Fuller read (a[7:0]==FULLER_ADDR): oe=1, dout = AND over Fuller-mode ports of {~fire1,~fire2,2'b11,~right,~left,~down,~up}. Result is 8'hFF if no port is in Fuller mode.
- Keyboard read (a[0]==0, iorq_n=0, rd_n=0): kbdcol_out = kbdcol_in AND each term below. Otherwise kbdcol_out = kbdcol_in, oe=0, dout=8'hFF.
  - a[12]==0: Sinclair P1 term {~left,~right,~down,~up,~fire1}; Cursor term {~down,~up,~right,~fire2,~fire1}.
  - a[11]==0: Sinclair P2 term {~fire1,~up,~down,~right,~left}; Cursor term {~left,4'b1111}.
  - a[8]==0: Sinclair P1 term {2'b11,~fire2,2'b11}; Sinclair P2 term {3'b111,~fire2,1'b1}.
- Multiple ports in the same mode merge by OR (active-high) or AND (active-low).

## Timing
- Reset: all debounce states 0 (released), counters 0, F=0, configs at reset values. Outputs follow combinationally: oe=0, dout=8'hFF, kbdcol_out=kbdcol_in.
- Press latency: 2 sync cycles plus limit cycles from a stable pin edge to the debounced change. Release latency is the same.
- A glitch shorter than the limit produces no change. Any mismatch-free cycle restarts the count.
- The read path is combinational from registered state: same-cycle response to address/strobe.
- A config write takes effect on the read path one cycle after the strobe.
- Autofire fires immediately on press (F=0, F[R]=0 → active). Period is 2^(R+1) frames, duty 50%.
- A counter wraps F 15→0 silently.
- A retrace edge coinciding with release clears F; clear wins.
- reset_n assertion mid-press clears state immediately. After release, a held button needs a full debounce period before it is seen again.

## Test plan
- Reset: hold reset_n=0 → oe=0, dout=8'hFF, conf0 read = 8'h01, conf1 read = 8'h02.
- Debounce: port0 up pin low for DEB_CYCLES+2 → Kempston read 8'h08. A pulse of DEB_CYCLES-10 cycles → 8'h00 throughout.
- Autofire: conf0=8'h19 (Kempston, autofire, R=1) with fire1 held → bit4 of Kempston read is 1 for 2 frames and 0 for 2 frames, repeating. Release → F=0.
- Protocol merge: conf0=8'h05, conf1=8'h05, port0 up, port1 fire1 → Fuller read 8'h7E.
- Keyboard: conf1=8'h02, port1 left+fire1, a=16'hEFFE, kbdcol_in=5'h1F → kbdcol_out=5'h0E. With a=16'hFEFE → 5'h1F.
- ZX-Uno priority: zxuno_regrd at CONFBASE+1 during a Kempston read → dout = conf1, oe=1. A write of 8'hFF reads back 8'h3F.

Source files
------------

// File: rtl/joystick_mapper_multi_if.sv
// CPU-side bus into the joystick mapper: Z80 I/O read cycle plus ZX-Uno
// register access. The mapper is the slave; the CPU/bus glue is the master.
interface joystick_mapper_multi_if;
  logic [15:0] a;
  logic        iorq_n;
  logic        rd_n;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        oe;
  logic [7:0]  zxuno_addr;
  logic        zxuno_regrd;
  logic        zxuno_regwr;

  modport master (output a, iorq_n, rd_n, din, zxuno_addr, zxuno_regrd, zxuno_regwr,
                  input  dout, oe);
  modport slave  (input  a, iorq_n, rd_n, din, zxuno_addr, zxuno_regrd, zxuno_regwr,
                  output dout, oe);
endinterface

// File: rtl/joystick_mapper_multi.sv
// N-port joystick front end: per-port sync/debounce/autofire lanes, per-port
// protocol config registers, and a combinational Kempston/Fuller/keyboard read mux.

module jm_debounce #(
  parameter int LIMIT = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_n,
  output logic state
);
  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [1:0]    sync_q, sync_d;
  logic          s_q, s_d;
  logic [CW-1:0] c_q, c_d;
  logic          level;

  always_comb begin
    sync_d = {sync_q[0], pin_n};
    level  = ~sync_q[1];
    s_d    = s_q;
    c_d    = '0;
    if (level != s_q) begin
      if (c_q == CW'(LIMIT - 1)) s_d = level;
      else                       c_d = c_q + CW'(1);
    end
  end

  // Synchronizer resets to the idle (released, pin high) level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
      s_q    <= 1'b0;
      c_q    <= '0;
    end else begin
      sync_q <= sync_d;
      s_q    <= s_d;
      c_q    <= c_d;
    end
  end

  assign state = s_q;
endmodule

module jm_port #(
  parameter int DEB_CYCLES      = 140000,
  parameter int FIRE_DEB_CYCLES = 28000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] pin_n,
  input  logic       af_en,
  input  logic [1:0] rate,
  input  logic       frame_tick,
  output logic [5:0] btn
);
  logic [5:0] deb;
  logic [3:0] f_q, f_d;

  for (genvar b = 0; b < 6; b++) begin : g_bit
    localparam int LIM = (b >= 4) ? FIRE_DEB_CYCLES : DEB_CYCLES;
    jm_debounce #(.LIMIT(LIM)) u_deb (
      .clk    (clk),
      .reset_n(reset_n),
      .pin_n  (pin_n[b]),
      .state  (deb[b])
    );
  end

  // Release clears the frame count even on a retrace edge.
  always_comb begin
    f_d = f_q;
    if (!deb[4])         f_d = '0;
    else if (frame_tick) f_d = f_q + 4'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) f_q <= '0;
    else          f_q <= f_d;
  end

  assign btn = {deb[5], deb[4] & (~af_en | ~f_q[rate]), deb[3:0]};
endmodule

module joystick_mapper_multi #(
  parameter int         NUM_PORTS       = 2,
  parameter int         DEB_CYCLES      = 140000,
  parameter int         FIRE_DEB_CYCLES = 28000,
  parameter logic [7:0] CONFBASE        = 8'h06,
  parameter logic [7:0] KEMPSTON_ADDR   = 8'h1F,
  parameter logic [7:0] FULLER_ADDR     = 8'h7F
) (
  input  logic                   clk,
  input  logic                   reset_n,
  joystick_mapper_multi_if.slave bus,
  input  logic [6*NUM_PORTS-1:0] joy_in,
  input  logic [4:0]             kbdcol_in,
  output logic [4:0]             kbdcol_out,
  input  logic                   vertical_retrace_int_n
);
  function automatic logic [5:0] conf_rst(int i);
    return (i == 0) ? 6'h01 : (i == 1) ? 6'h02 : 6'h00;
  endfunction

  logic [NUM_PORTS-1:0][5:0] conf_q, conf_d;
  logic [NUM_PORTS-1:0][5:0] btn;
  logic                      vr_q;
  logic                      frame_tick;

  assign frame_tick = vertical_retrace_int_n & ~vr_q;

  always_comb begin
    conf_d = conf_q;
    for (int i = 0; i < NUM_PORTS; i++)
      if (bus.zxuno_regwr && bus.zxuno_addr == 8'(CONFBASE + i)) conf_d[i] = bus.din[5:0];
  end

  // Retrace history resets high so leaving reset never fakes an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vr_q <= 1'b1;
      for (int i = 0; i < NUM_PORTS; i++) conf_q[i] <= conf_rst(i);
    end else begin
      vr_q   <= vertical_retrace_int_n;
      conf_q <= conf_d;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    jm_port #(.DEB_CYCLES(DEB_CYCLES), .FIRE_DEB_CYCLES(FIRE_DEB_CYCLES)) u_port (
      .clk       (clk),
      .reset_n   (reset_n),
      .pin_n     (joy_in[6*p +: 6]),
      .af_en     (conf_q[p][3]),
      .rate      (conf_q[p][5:4]),
      .frame_tick(frame_tick),
      .btn       (btn[p])
    );
  end

  logic       z80_rd, zx_hit;
  logic [7:0] zx_data, kemp, full, dout_c;
  logic [4:0] kbd;
  logic [5:0] b;
  logic [2:0] mode;
  logic       oe_c;

  // btn bits: 5 fire2, 4 fire1, 3 up, 2 down, 1 left, 0 right (active high).
  always_comb begin
    z80_rd  = ~bus.iorq_n & ~bus.rd_n;
    zx_hit  = 1'b0;
    zx_data = 8'h00;
    kemp    = 8'h00;
    full    = 8'hFF;
    kbd     = kbdcol_in;
    b       = '0;
    mode    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      b    = btn[p];
      mode = conf_q[p][2:0];
      if (mode == 3'd1) kemp |= {2'b00, b};
      if (mode == 3'd5) full &= {~b[4], ~b[5], 2'b11, ~b[0], ~b[1], ~b[2], ~b[3]};
      if (!bus.a[12]) begin
        if (mode == 3'd2) kbd &= {~b[1], ~b[0], ~b[2], ~b[3], ~b[4]};
        if (mode == 3'd4) kbd &= {~b[2], ~b[3], ~b[0], ~b[5], ~b[4]};
      end
      if (!bus.a[11]) begin
        if (mode == 3'd3) kbd &= {~b[4], ~b[3], ~b[2], ~b[0], ~b[1]};
        if (mode == 3'd4) kbd &= {~b[1], 4'b1111};
      end
      if (!bus.a[8]) begin
        if (mode == 3'd2) kbd &= {2'b11, ~b[5], 2'b11};
        if (mode == 3'd3) kbd &= {3'b111, ~b[5], 1'b1};
      end
      if (bus.zxuno_regrd && bus.zxuno_addr == 8'(CONFBASE + p)) begin
        zx_hit  = 1'b1;
        zx_data = {2'b00, conf_q[p]};
      end
    end

    oe_c   = 1'b0;
    dout_c = 8'hFF;
    if (zx_hit) begin
      oe_c   = 1'b1;
      dout_c = zx_data;
    end else if (z80_rd && bus.a[7:0] == KEMPSTON_ADDR) begin
      oe_c   = 1'b1;
      dout_c = kemp;
    end else if (z80_rd && bus.a[7:0] == FULLER_ADDR) begin
      oe_c   = 1'b1;
      dout_c = full;
    end
  end

  assign kbdcol_out = (z80_rd && !bus.a[0]) ? kbd : kbdcol_in;
  assign bus.oe     = oe_c;
  assign bus.dout   = dout_c;

  logic unused_bits;
  assign unused_bits = ^{bus.a[15:13], bus.a[10:9], bus.din[7:6]};
endmodule

// File: tb/tb_joystick_mapper_multi.sv
// Directed bench for joystick_mapper_multi with short debounce limits.
module tb_joystick_mapper_multi;
  localparam int DEB  = 20;
  localparam int FDEB = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] joy;
  logic [4:0]  kbdcol_in;
  logic [4:0]  kbdcol_out;
  logic        vr;
  int          chk = 0;
  int          pass = 0;

  joystick_mapper_multi_if bus ();

  joystick_mapper_multi #(
    .NUM_PORTS(2), .DEB_CYCLES(DEB), .FIRE_DEB_CYCLES(FDEB)
  ) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .bus                   (bus),
    .joy_in                (joy),
    .kbdcol_in             (kbdcol_in),
    .kbdcol_out            (kbdcol_out),
    .vertical_retrace_int_n(vr)
  );

  always #5 clk = ~clk;

  task automatic bus_idle();
    bus.a = 16'hFFFF; bus.iorq_n = 1'b1; bus.rd_n = 1'b1; bus.din = 8'h00;
    bus.zxuno_addr = 8'h00; bus.zxuno_regrd = 1'b0; bus.zxuno_regwr = 1'b0;
  endtask

  task automatic z80_rd(input logic [15:0] addr);
    bus.a = addr; bus.iorq_n = 1'b0; bus.rd_n = 1'b0;
  endtask

  task automatic zx_wr(input logic [7:0] ad, input logic [7:0] d);
    @(negedge clk);
    bus.zxuno_addr = ad; bus.din = d; bus.zxuno_regwr = 1'b1;
    @(negedge clk);
    bus.zxuno_regwr = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame();
    @(negedge clk); vr = 1'b0;
    @(negedge clk); vr = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; joy = 12'hFFF; kbdcol_in = 5'h0A; vr = 1'b1;
    bus_idle();
    wait_cyc(3); #1;
    chk++; if (bus.oe !== 1'b0) $display("FAIL reset_oe: got %b want 0", bus.oe); else pass++;
    chk++; if (bus.dout !== 8'hFF) $display("FAIL reset_dout: got %h want ff", bus.dout); else pass++;
    chk++; if (kbdcol_out !== 5'h0A) $display("FAIL reset_kbd: got %h want 0a", kbdcol_out); else pass++;
    bus.zxuno_regrd = 1'b1; bus.zxuno_addr = 8'h06; #1;
    chk++; if (bus.dout !== 8'h01 || bus.oe !== 1'b1) $display("FAIL reset_conf0: got %h/%b want 01/1", bus.dout, bus.oe); else pass++;
    bus.zxuno_addr = 8'h07; #1;
    chk++; if (bus.dout !== 8'h02) $display("FAIL reset_conf1: got %h want 02", bus.dout); else pass++;
    bus_idle();
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_debounce();
    z80_rd(16'h001F);
    @(negedge clk); joy[3] = 1'b0;
    wait_cyc(DEB + 1); #1;
    chk++; if (bus.dout !== 8'h00) $display("FAIL deb_early: got %h want 00", bus.dout); else pass++;
    wait_cyc(1); #1;
    chk++; if (bus.dout !== 8'h08) $display("FAIL deb_press: got %h want 08", bus.dout); else pass++;
    joy[3] = 1'b1;
    wait_cyc(DEB + 1); #1;
    chk++; if (bus.dout !== 8'h08) $display("FAIL deb_rel_early: got %h want 08", bus.dout); else pass++;
    wait_cyc(1); #1;
    chk++; if (bus.dout !== 8'h00) $display("FAIL deb_release: got %h want 00", bus.dout); else pass++;
    joy[3] = 1'b0;
    for (int i = 0; i < DEB - 10; i++) begin
      @(negedge clk); #1;
      chk++; if (bus.dout !== 8'h00) $display("FAIL deb_glitch_in: cyc %0d got %h want 00", i, bus.dout); else pass++;
    end
    joy[3] = 1'b1;
    for (int i = 0; i < DEB + 4; i++) begin
      @(negedge clk); #1;
      chk++; if (bus.dout !== 8'h00) $display("FAIL deb_glitch_out: cyc %0d got %h want 00", i, bus.dout); else pass++;
    end
    bus_idle();
  endtask

  task automatic test_autofire();
    logic [7:0] exp;
    zx_wr(8'h06, 8'h19);
    bus.zxuno_regrd = 1'b1; bus.zxuno_addr = 8'h06; #1;
    chk++; if (bus.dout !== 8'h19) $display("FAIL af_conf: got %h want 19", bus.dout); else pass++;
    bus.zxuno_regrd = 1'b0;
    z80_rd(16'h001F);
    joy[4] = 1'b0;
    wait_cyc(FDEB + 2); #1;
    chk++; if (bus.dout !== 8'h10) $display("FAIL af_first: got %h want 10", bus.dout); else pass++;
    for (int k = 1; k <= 18; k++) begin
      frame(); #1;
      exp = ((k & 2) != 0) ? 8'h00 : 8'h10;
      chk++; if (bus.dout !== exp) $display("FAIL af_frame: frame %0d got %h want %h", k, bus.dout, exp); else pass++;
    end
    joy[4] = 1'b1;
    wait_cyc(FDEB + 2); #1;
    chk++; if (bus.dout !== 8'h00) $display("FAIL af_release: got %h want 00", bus.dout); else pass++;
    joy[4] = 1'b0;
    wait_cyc(FDEB + 2); #1;
    chk++; if (bus.dout !== 8'h10) $display("FAIL af_repress: got %h want 10", bus.dout); else pass++;
    joy[4] = 1'b1;
    wait_cyc(FDEB + 2);
    bus_idle();
  endtask

  task automatic test_merge();
    zx_wr(8'h06, 8'h05);
    zx_wr(8'h07, 8'h05);
    joy[3] = 1'b0; joy[10] = 1'b0;
    wait_cyc(DEB + 2);
    z80_rd(16'h007F); #1;
    chk++; if (bus.dout !== 8'h7E || bus.oe !== 1'b1) $display("FAIL merge_fuller: got %h/%b want 7e/1", bus.dout, bus.oe); else pass++;
    z80_rd(16'h001F); #1;
    chk++; if (bus.dout !== 8'h00 || bus.oe !== 1'b1) $display("FAIL merge_no_kemp: got %h/%b want 00/1", bus.dout, bus.oe); else pass++;
    bus_idle();
  endtask

  task automatic test_keyboard();
    zx_wr(8'h06, 8'h00);
    zx_wr(8'h07, 8'h02);
    joy[3] = 1'b1; joy[7] = 1'b0;
    wait_cyc(DEB + 2);
    kbdcol_in = 5'h1F;
    z80_rd(16'hEFFE); #1;
    chk++; if (kbdcol_out !== 5'h0E) $display("FAIL kbd_sp1: got %h want 0e", kbdcol_out); else pass++;
    chk++; if (bus.oe !== 1'b0 || bus.dout !== 8'hFF) $display("FAIL kbd_oe: got %h/%b want ff/0", bus.dout, bus.oe); else pass++;
    z80_rd(16'hFEFE); #1;
    chk++; if (kbdcol_out !== 5'h1F) $display("FAIL kbd_sp1_fire2row: got %h want 1f", kbdcol_out); else pass++;
    z80_rd(16'h007F); #1;
    chk++; if (bus.dout !== 8'hFF || bus.oe !== 1'b1) $display("FAIL no_fuller: got %h/%b want ff/1", bus.dout, bus.oe); else pass++;
    bus_idle(); bus.a = 16'hEFFE; kbdcol_in = 5'h15; #1;
    chk++; if (kbdcol_out !== 5'h15) $display("FAIL kbd_pass: got %h want 15", kbdcol_out); else pass++;
    kbdcol_in = 5'h1F;
    z80_rd(16'hEFFE);
    @(negedge clk);
    bus.zxuno_addr = 8'h07; bus.din = 8'h04; bus.zxuno_regwr = 1'b1; #1;
    chk++; if (kbdcol_out !== 5'h0E) $display("FAIL wr_same_cycle: got %h want 0e", kbdcol_out); else pass++;
    @(negedge clk); bus.zxuno_regwr = 1'b0; #1;
    chk++; if (kbdcol_out !== 5'h1E) $display("FAIL kbd_cursor12: got %h want 1e", kbdcol_out); else pass++;
    z80_rd(16'hF7FE); #1;
    chk++; if (kbdcol_out !== 5'h0F) $display("FAIL kbd_cursor11: got %h want 0f", kbdcol_out); else pass++;
    bus_idle();
  endtask

  task automatic test_zx_priority();
    z80_rd(16'h001F);
    bus.zxuno_regrd = 1'b1; bus.zxuno_addr = 8'h07; #1;
    chk++; if (bus.dout !== 8'h04 || bus.oe !== 1'b1) $display("FAIL zx_prio: got %h/%b want 04/1", bus.dout, bus.oe); else pass++;
    zx_wr(8'h07, 8'hFF); #1;
    chk++; if (bus.dout !== 8'h3F) $display("FAIL zx_wr_mask: got %h want 3f", bus.dout); else pass++;
    bus.zxuno_addr = 8'h08; #1;
    chk++; if (bus.dout !== 8'h00 || bus.oe !== 1'b1) $display("FAIL zx_miss_kemp: got %h/%b want 00/1", bus.dout, bus.oe); else pass++;
    bus_idle();
  endtask

  task automatic test_reset_midpress();
    joy = 12'hFFF;
    zx_wr(8'h06, 8'h01);
    joy[0] = 1'b0;
    wait_cyc(DEB + 2);
    z80_rd(16'h001F); #1;
    chk++; if (bus.dout !== 8'h01) $display("FAIL mid_pressed: got %h want 01", bus.dout); else pass++;
    @(negedge clk); reset_n = 1'b0; #1;
    chk++; if (bus.dout !== 8'h00) $display("FAIL mid_reset_clear: got %h want 00", bus.dout); else pass++;
    bus.zxuno_regrd = 1'b1; bus.zxuno_addr = 8'h07; #1;
    chk++; if (bus.dout !== 8'h02) $display("FAIL mid_reset_conf1: got %h want 02", bus.dout); else pass++;
    bus.zxuno_regrd = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    wait_cyc(DEB + 1); #1;
    chk++; if (bus.dout !== 8'h00) $display("FAIL mid_redeb_early: got %h want 00", bus.dout); else pass++;
    wait_cyc(1); #1;
    chk++; if (bus.dout !== 8'h01) $display("FAIL mid_redeb: got %h want 01", bus.dout); else pass++;
    bus_idle();
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_autofire();
    test_merge();
    test_keyboard();
    test_zx_priority();
    test_reset_midpress();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
